// File: rtl/vga_wave_scope.sv
// VGA timing generator with multi-channel scrolling sine-trace renderer.
// Two-stage pixel pipeline: sine lookup, then hit test and colour select.
module vga_wave_scope #(
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int H_ACTIVE  = 640,
    parameter int H_FRONT   = 16,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int V_ACTIVE  = 480,
    parameter int V_FRONT   = 10,
    parameter int CNT_W     = 11,
    parameter int NUM_CH    = 2,
    parameter int AMPLITUDE = 50,
    parameter int CENTER_Y  = 240,
    parameter int THICK_MAX = 7,
    parameter int THICK_RST = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              show_cl,
    input  logic              plus_thick,
    input  logic              minus_thick,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic [7:0]        phase_step,
    output logic [23:0]       vga_rgb,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              vga_blank_n,
    output logic              frame_start
);
    localparam int H_TOTAL    = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL    = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int H_START    = H_SYNC + H_BACK;
    localparam int V_START    = V_SYNC + V_BACK;
    localparam int CH_SPACING = 256 / NUM_CH;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_SYNC_C = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_C = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] H_BEG_C  = CNT_W'(H_START);
    localparam logic [CNT_W-1:0] H_END_C  = CNT_W'(H_START + H_ACTIVE);
    localparam logic [CNT_W-1:0] V_BEG_C  = CNT_W'(V_START);
    localparam logic [CNT_W-1:0] V_END_C  = CNT_W'(V_START + V_ACTIVE);

    localparam logic [23:0] CH_COLOUR [4] = '{24'h00FFFF, 24'hFF00FF, 24'h00FF00, 24'hFFFF00};

    function automatic int sine_q8(input int i);
        real r;
        r = 256.0 * $sin(2.0 * 3.141592653589793 * real'(i) / 256.0);
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
    endfunction

    // Elaboration-time constant table, signed Q8, peak +/-256.
    logic signed [9:0] sine_rom [256];
    for (genvar i = 0; i < 256; i++) begin : g_sine
        assign sine_rom[i] = 10'(sine_q8(i));
    end

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             frame_bound;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    assign frame_bound = (h_cnt == '0) && (v_cnt == '0);

    logic              show_q, plus_q, minus_q;
    logic              show_rise, plus_rise, minus_rise;
    logic [7:0]        thick, thick_pend;
    logic              cl_on, cl_pend;
    logic [NUM_CH-1:0] ch_en_q;
    logic [7:0]        step_q, phase;

    assign show_rise  = show_cl & ~show_q;
    assign plus_rise  = plus_thick & ~plus_q;
    assign minus_rise = minus_thick & ~minus_q;

    // Pending values collect requests all frame; live values move only at the frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            show_q     <= 1'b0;
            plus_q     <= 1'b0;
            minus_q    <= 1'b0;
            thick      <= 8'(THICK_RST);
            thick_pend <= 8'(THICK_RST);
            cl_on      <= 1'b1;
            cl_pend    <= 1'b1;
            ch_en_q    <= '0;
            step_q     <= '0;
            phase      <= '0;
        end else begin
            show_q  <= show_cl;
            plus_q  <= plus_thick;
            minus_q <= minus_thick;
            if (plus_rise && !minus_rise && thick_pend < 8'(THICK_MAX))
                thick_pend <= thick_pend + 1'b1;
            else if (minus_rise && !plus_rise && thick_pend != '0)
                thick_pend <= thick_pend - 1'b1;
            if (show_rise)
                cl_pend <= ~cl_pend;
            if (frame_bound) begin
                thick   <= thick_pend;
                cl_on   <= cl_pend;
                ch_en_q <= ch_en;
                step_q  <= phase_step;
                phase   <= phase + step_q;
            end
        end
    end

    logic [7:0] x_idx;
    logic [7:0] idx [NUM_CH];

    always_comb begin
        x_idx = 8'((int'(h_cnt) - H_START) * 256 / H_ACTIVE);
        for (int k = 0; k < NUM_CH; k++)
            idx[k] = x_idx + phase + 8'(k * CH_SPACING);
    end

    logic signed [9:0] sine_s1 [NUM_CH];
    logic [CNT_W-1:0]  v_s1;
    logic              act_s1, hs_s1, vs_s1, fs_s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) sine_s1[k] <= '0;
            v_s1   <= '0;
            act_s1 <= 1'b0;
            hs_s1  <= 1'b1;
            vs_s1  <= 1'b1;
            fs_s1  <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) sine_s1[k] <= sine_rom[idx[k]];
            v_s1   <= v_cnt;
            act_s1 <= (h_cnt >= H_BEG_C) && (h_cnt < H_END_C) &&
                      (v_cnt >= V_BEG_C) && (v_cnt < V_END_C);
            hs_s1  <= (h_cnt >= H_SYNC_C);
            vs_s1  <= (v_cnt >= V_SYNC_C);
            fs_s1  <= frame_bound;
        end
    end

    logic [23:0] rgb_nxt;

    // Scan channels high to low so the lowest-index hit ends up on top.
    always_comb begin
        int y, off, dy;
        rgb_nxt = '0;
        off     = 0;
        dy      = 0;
        y       = int'(v_s1) - V_START;
        if (act_s1) begin
            if (cl_on && y == CENTER_Y) begin
                rgb_nxt = 24'hFFFFFF;
            end else begin
                for (int k = NUM_CH - 1; k >= 0; k--) begin
                    off = (int'(sine_s1[k]) * AMPLITUDE) >>> 8;
                    dy  = y - (CENTER_Y - off);
                    if (ch_en_q[k] && dy <= int'(thick) && -dy <= int'(thick))
                        rgb_nxt = CH_COLOUR[k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_rgb     <= '0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            vga_rgb     <= rgb_nxt;
            vga_hs      <= hs_s1;
            vga_vs      <= vs_s1;
            vga_blank_n <= act_s1;
            frame_start <= fs_s1;
        end
    end
endmodule
